// File: rtl/seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// seq_magnitude_comparator
//
// Multi-cycle WIDTH-bit magnitude comparator. Operands are latched on start and
// compared CHUNK bits per clock, most significant chunk first. The scan stops
// on the first differing chunk, so latency depends on the data. Both unsigned
// and two's complement compares are supported.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        compare request, accepted in IDLE or DONE
//   signed_mode  1 = two's complement, 0 = unsigned (latched with start)
//   A, B         WIDTH-bit operands (latched with start)
//   busy         high while the chunk scan is running
//   done         one-cycle pulse when the result flags have just been updated
//   A_less_B     registered result flag
//   A_greater_B  registered result flag
//   A_equal_B    registered result flag
// -----------------------------------------------------------------------------
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_less_B,
    output logic             A_greater_B,
    output logic             A_equal_B
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t state, state_n;

    logic [IDX_W-1:0] idx, idx_n;
    // Result flags packed as {less, greater, equal}.
    logic [2:0]       flags, flags_n;
    logic             load;

    logic [WIDTH-1:0] a_p0, b_p0;
    logic [CHUNK-1:0] chunk_a, chunk_b;

    // Flipping the sign bit maps two's complement order onto unsigned order,
    // so the scan below only ever needs an unsigned chunk compare.
    function automatic logic [WIDTH-1:0] to_unsigned_order(
        input logic [WIDTH-1:0] v,
        input logic             is_signed
    );
        return is_signed ? (v ^ MSB_MASK) : v;
    endfunction

    function automatic logic [CHUNK-1:0] get_chunk(
        input logic [WIDTH-1:0] v,
        input logic [IDX_W-1:0] i
    );
        return v[i*CHUNK +: CHUNK];
    endfunction

    assign chunk_a = get_chunk(a_p0, idx);
    assign chunk_b = get_chunk(b_p0, idx);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        flags_n = flags;
        load    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_n   = IDX_TOP;
                    state_n = S_COMPARE;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_COMPARE: begin
                if (chunk_a > chunk_b) begin
                    flags_n = 3'b010;
                    state_n = S_DONE;
                end else if (chunk_a < chunk_b) begin
                    flags_n = 3'b100;
                    state_n = S_DONE;
                end else if (idx == '0) begin
                    flags_n = 3'b001;
                    state_n = S_DONE;
                end else begin
                    idx_n = idx - IDX_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Control state: reset clears the FSM, scan index and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            flags <= 3'b000;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            flags <= flags_n;
        end
    end

    // Operand latch: contents only matter once the FSM is in COMPARE.
    always_ff @(posedge clk) begin
        if (load) begin
            a_p0 <= to_unsigned_order(A, signed_mode);
            b_p0 <= to_unsigned_order(B, signed_mode);
        end
    end

    assign busy        = (state == S_COMPARE);
    assign done        = (state == S_DONE);
    assign A_less_B    = flags[2];
    assign A_greater_B = flags[1];
    assign A_equal_B   = flags[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [15:0] B = 16'h0000;
    logic        busy, done, A_less_B, A_greater_B, A_equal_B;

    int checks = 0;
    int errors = 0;

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .A_less_B    (A_less_B),
        .A_greater_B (A_greater_B),
        .A_equal_B   (A_equal_B)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count busy cycles until done is seen (bounded). Leaves the bench
    // positioned in the done cycle when got_done is set.
    task automatic wait_done(output int nbusy, output bit got_done);
        nbusy    = 0;
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) nbusy++;
            tick();
        end
    endtask

    // Issue a single-cycle start with the given operands, then wait for done.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sm,
                          output int nbusy, output bit got_done);
        A           = a;
        B           = b;
        signed_mode = sm;
        start       = 1'b1;
        tick();
        start = 1'b0;
        wait_done(nbusy, got_done);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl busy/done=%b expected 00", {busy, done});
        end
        checks++;
        if ({A_less_B, A_greater_B, A_equal_B} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags lt/gt/eq=%b expected 000", {A_less_B, A_greater_B, A_equal_B});
        end
    endtask

    task automatic test_unsigned_early_exit();
        int nb;
        bit gd;
        run_op(16'h8000, 16'h7FFF, 1'b0, nb, gd);
        checks++;
        if (!gd || nb != 1) begin
            errors++;
            $display("FAIL early_exit_latency got_done=%0d busy_cycles=%0d expected 1/1", gd, nb);
        end
        checks++;
        if ({A_less_B, A_greater_B, A_equal_B} !== 3'b010) begin
            errors++;
            $display("FAIL early_exit_flags lt/gt/eq=%b expected 010", {A_less_B, A_greater_B, A_equal_B});
        end
        tick();
        checks++;
        if ({busy, done, A_less_B, A_greater_B, A_equal_B} !== 5'b00010) begin
            errors++;
            $display("FAIL done_pulse_hold busy/done/flags=%b expected 00010",
                     {busy, done, A_less_B, A_greater_B, A_equal_B});
        end
    endtask

    task automatic test_full_scan();
        int nb;
        bit gd;
        run_op(16'h1234, 16'h1235, 1'b0, nb, gd);
        checks++;
        if (!gd || nb != 4) begin
            errors++;
            $display("FAIL full_scan_less_latency got_done=%0d busy_cycles=%0d expected 1/4", gd, nb);
        end
        checks++;
        if ({A_less_B, A_greater_B, A_equal_B} !== 3'b100) begin
            errors++;
            $display("FAIL full_scan_less_flags lt/gt/eq=%b expected 100", {A_less_B, A_greater_B, A_equal_B});
        end
        tick();
        run_op(16'hABCD, 16'hABCD, 1'b0, nb, gd);
        checks++;
        if (!gd || nb != 4) begin
            errors++;
            $display("FAIL full_scan_equal_latency got_done=%0d busy_cycles=%0d expected 1/4", gd, nb);
        end
        checks++;
        if ({A_less_B, A_greater_B, A_equal_B} !== 3'b001) begin
            errors++;
            $display("FAIL full_scan_equal_flags lt/gt/eq=%b expected 001", {A_less_B, A_greater_B, A_equal_B});
        end
        tick();
    endtask

    task automatic test_signed_modes();
        int nb;
        bit gd;
        run_op(16'hFFFF, 16'h0001, 1'b1, nb, gd);
        checks++;
        if (!gd || nb != 1 || {A_less_B, A_greater_B, A_equal_B} !== 3'b100) begin
            errors++;
            $display("FAIL signed_neg1_vs_1 got_done=%0d busy=%0d flags=%b expected 1/1/100",
                     gd, nb, {A_less_B, A_greater_B, A_equal_B});
        end
        tick();
        run_op(16'hFFFF, 16'h0001, 1'b0, nb, gd);
        checks++;
        if (!gd || nb != 1 || {A_less_B, A_greater_B, A_equal_B} !== 3'b010) begin
            errors++;
            $display("FAIL unsigned_ffff_vs_1 got_done=%0d busy=%0d flags=%b expected 1/1/010",
                     gd, nb, {A_less_B, A_greater_B, A_equal_B});
        end
        tick();
        run_op(16'h8000, 16'h7FFF, 1'b1, nb, gd);
        checks++;
        if (!gd || nb != 1 || {A_less_B, A_greater_B, A_equal_B} !== 3'b100) begin
            errors++;
            $display("FAIL signed_min_vs_max got_done=%0d busy=%0d flags=%b expected 1/1/100",
                     gd, nb, {A_less_B, A_greater_B, A_equal_B});
        end
        tick();
        // Signed compare of two negatives differing only in the low chunk.
        run_op(16'hFFF0, 16'hFFF1, 1'b1, nb, gd);
        checks++;
        if (!gd || nb != 4 || {A_less_B, A_greater_B, A_equal_B} !== 3'b100) begin
            errors++;
            $display("FAIL signed_fff0_vs_fff1 got_done=%0d busy=%0d flags=%b expected 1/4/100",
                     gd, nb, {A_less_B, A_greater_B, A_equal_B});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int nb;
        bit gd;
        // Previous result is less=1; a held start must not disturb it or the
        // latched operands while the scan runs.
        A           = 16'h1235;
        B           = 16'h1234;
        signed_mode = 1'b0;
        start       = 1'b1;
        tick();
        A = 16'h0000;
        B = 16'hFFFF;
        checks++;
        if ({busy, A_less_B, A_greater_B, A_equal_B} !== 4'b1100) begin
            errors++;
            $display("FAIL flags_held_during_busy busy/flags=%b expected 1100",
                     {busy, A_less_B, A_greater_B, A_equal_B});
        end
        wait_done(nb, gd);
        checks++;
        if (!gd || nb != 4 || {A_less_B, A_greater_B, A_equal_B} !== 3'b010) begin
            errors++;
            $display("FAIL start_held_result got_done=%0d busy=%0d flags=%b expected 1/4/010",
                     gd, nb, {A_less_B, A_greater_B, A_equal_B});
        end
        // start is still high in the DONE cycle: accepted at this edge.
        tick();
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL back_to_back_accept busy/done=%b expected 10", {busy, done});
        end
        wait_done(nb, gd);
        checks++;
        if (!gd || nb != 1 || {A_less_B, A_greater_B, A_equal_B} !== 3'b100) begin
            errors++;
            $display("FAIL back_to_back_result got_done=%0d busy=%0d flags=%b expected 1/1/100",
                     gd, nb, {A_less_B, A_greater_B, A_equal_B});
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int  nb;
        bit  gd;
        bit  saw_done;
        A           = 16'h1234;
        B           = 16'h1235;
        signed_mode = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, A_less_B, A_greater_B, A_equal_B} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_mid_op busy/done/flags=%b expected 00000",
                     {busy, done, A_less_B, A_greater_B, A_equal_B});
        end
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL aborted_no_done saw busy/done=1 expected 0");
        end
        run_op(16'h8000, 16'h7FFF, 1'b0, nb, gd);
        checks++;
        if (!gd || nb != 1 || {A_less_B, A_greater_B, A_equal_B} !== 3'b010) begin
            errors++;
            $display("FAIL after_reset_op got_done=%0d busy=%0d flags=%b expected 1/1/010",
                     gd, nb, {A_less_B, A_greater_B, A_equal_B});
        end
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_unsigned_early_exit();
        test_full_scan();
        test_signed_modes();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Multi-cycle, parametrised magnitude comparator that generalises the team's fixed 4-bit combinational comparator to WIDTH-bit operands. It examines CHUNK bits per clock, MSB chunk first, and terminates early on the first differing chunk. It supports signed (two's complement) and unsigned modes and uses a start/busy/done handshake. It sits beside the datapath where a wide compare does not fit in one cycle's timing budget.

Parameters:
WIDTH, 16, operand width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
(derived) NUM_CHUNKS = WIDTH/CHUNK; chunk index counter width = clog2(NUM_CHUNKS), minimum 1.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, synchronous, active-high.
start  input  1  request a compare; sampled only when not busy.
signed_mode  input  1  1 = two's complement compare, 0 = unsigned; latched with start.
A  input  WIDTH  operand A; latched with start.
B  input  WIDTH  operand B; latched with start.
busy  output  1  high while in COMPARE.
done  output  1  one-cycle pulse: result flags just updated.
A_less_B  output  1  registered result flag.
A_greater_B  output  1  registered result flag.
A_equal_B  output  1  registered result flag.

Behaviour:
- Reset: rst high at a rising edge puts state in IDLE and clears busy, done and all three flags to 0. Reset overrides every other input, including mid-compare; an aborted compare produces no done.
- States:
  - IDLE: busy=0, done=0.
  - COMPARE: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle.
- Accept: start=1 at an edge while in IDLE or DONE latches A, B and signed_mode, sets idx=NUM_CHUNKS-1 and enters COMPARE. This allows back-to-back operation from DONE. Without start, DONE returns to IDLE.
- Start is ignored while in COMPARE. No queueing; the latched operands are unaffected.
- Signed mode: invert the MSB of both latched operands at latch time, then run the unsigned compare. This is required to be exactly equivalent to a two's complement compare.
- Each COMPARE cycle compares latched chunk idx, bits [idx*CHUNK+CHUNK-1 : idx*CHUNK]:
  - A chunk > B chunk: at the edge, set greater=1, less=0, equal=0; enter DONE.
  - A chunk < B chunk: at the edge, set less=1, greater=0, equal=0; enter DONE.
  - Chunks equal and idx==0: at the edge, set equal=1, less=0, greater=0; enter DONE.
  - Chunks equal and idx>0: idx decrements; stay in COMPARE.
- Latency: if the accept edge is E0 and n chunks are examined (1 <= n <= NUM_CHUNKS), done is high during the cycle following edge En. Worst case is NUM_CHUNKS+1 cycles from accept to done.
- Flags:
  - Flags hold their value until the next done updates them. They are not cleared on start.
  - After the first done, exactly one flag is high. Before any done, or after reset, all three flags are 0.
- CHUNK==WIDTH degenerates to a fixed latency of 1 compare cycle.

Test Plan:
1. Reset: with WIDTH=16, CHUNK=4, hold rst for 2 cycles -> busy=done=less=greater=equal=0, state IDLE.
2. Unsigned early exit: A=0x8000, B=0x7FFF, signed_mode=0, start for 1 cycle -> busy for 1 cycle, done in the cycle after E1, greater=1, less=0, equal=0.
3. Full scan: A=0x1234, B=0x1235, unsigned -> busy for 4 cycles, done after E4, less=1. Then A=B=0xABCD -> done after E4, equal=1, previous less cleared.
4. Signed vs unsigned: A=0xFFFF, B=0x0001 -> signed_mode=1 gives less=1 after E1; signed_mode=0 gives greater=1 after E1. Also A=0x8000, B=0x7FFF, signed -> less=1.
5. Handshake: start held high through a 4-cycle compare with operands changed mid-way -> the original operands' result is reported. Start=1 in the DONE cycle -> the new compare is accepted immediately and busy rises the next cycle.
6. Reset mid-operation: assert rst during the 2nd COMPARE cycle of A=0x1234, B=0x1235 -> next cycle busy=0, no done pulse, all flags 0. A later start operates normally.
